// File: rtl/bin_to_bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_pkg
//   Shared constants for the binary-to-BCD converter datapath.
//   - DEFAULT_WIDTH / DEFAULT_DIGITS : default binary width and BCD digit count
//   - state_t                        : FSM state encoding (IDLE/SHIFT/DONE)
//   - DIGIT_ADJ_THRESH / DIGIT_ADJ   : double-dabble correction constants
// -----------------------------------------------------------------------------
package bin_to_bcd_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_DIGITS = 5;

    // Encodings are fixed so other blocks and debug views can decode state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A digit >= 5 would become >= 10 after the shift; adding 3 first makes
    // the shift carry into the next digit instead.
    localparam logic [3:0] DIGIT_ADJ_THRESH = 4'd5;
    localparam logic [3:0] DIGIT_ADJ        = 4'd3;

endpackage : bin_to_bcd_pkg

// File: rtl/bin_to_bcd_dabble.sv
// -----------------------------------------------------------------------------
// dabble_digit
//   Single-digit double-dabble correction: adds 3 when the digit is >= 5.
//   Ports:
//     din  : working BCD digit (0..9 in normal operation)
//     dout : corrected digit, ready to be shifted left
// -----------------------------------------------------------------------------
module dabble_digit
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // din never exceeds 9 during a conversion, so din+3 <= 12 fits in 4 bits.
    assign dout = (din >= DIGIT_ADJ_THRESH) ? (din + DIGIT_ADJ) : din;

endmodule : dabble_digit

// File: rtl/bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd
//   Sequential double-dabble binary-to-BCD converter. One bit is shifted per
//   clock; a conversion takes WIDTH SHIFT cycles plus one DONE cycle, and a
//   start seen in DONE chains straight into the next conversion.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous active-low reset
//     start : conversion request (accepted in IDLE or DONE, ignored in SHIFT)
//     bin   : unsigned binary input, sampled on the accepting edge
//     busy  : high while shifting
//     done  : one-cycle pulse while the freshly updated bcd is presented
//     bcd   : packed BCD result, digit 0 (units) in bits [3:0]; held between
//             completions
//   DIGITS must be large enough to hold 2^WIDTH-1 in decimal.
// -----------------------------------------------------------------------------
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam int              BW       = DIGITS * 4;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  sreg;        // binary bits still to be shifted in
    logic [BW-1:0]     work;        // working BCD, never visible on bcd
    logic [BW-1:0]     work_adj;    // work after per-digit +3 correction
    logic [BW-1:0]     work_shift;  // corrected work shifted left, MSB of sreg in
    logic [CW-1:0]     cnt;         // shifts remaining

    logic              accept;
    logic              last_shift;

    // DONE accepts a new start so back-to-back conversions have no gap.
    assign accept     = start && (state != ST_SHIFT);
    // cnt is >= 1 whenever in SHIFT, so the decrement never wraps.
    assign last_shift = (state == ST_SHIFT) && (cnt == CNT_ONE);

    // ---------------------------------------------------------------------
    // Per-digit correction
    // ---------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            dabble_digit u_dabble (
                .din  (work[g*4 +: 4]),
                .dout (work_adj[g*4 +: 4])
            );
        end
    endgenerate

    assign work_shift = {work_adj[BW-2:0], sreg[WIDTH-1]};

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode the state register only; no path from start to done.
    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            work <= '0;
            cnt  <= '0;
            bcd  <= '0;
        end else begin
            if (accept) begin
                sreg <= bin;
                work <= '0;
                cnt  <= CNT_LOAD;
            end else if (state == ST_SHIFT) begin
                sreg <= sreg << 1;
                work <= work_shift;
                cnt  <= cnt - CNT_ONE;
            end
            // Capture the final shifted value on the edge that enters DONE,
            // so bcd is already valid during the done cycle.
            if (last_shift) begin
                bcd <= work_shift;
            end
        end
    end

endmodule : bin_to_bcd

// File: tb/tb_bin_to_bcd.sv
module tb_bin_to_bcd;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int LAT    = WIDTH + 1;   // edges from accept (inclusive) to done
    localparam int NRAND  = 2000;

    logic              clk;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  bin;
    logic              busy;
    logic              done;
    logic [DIGITS*4-1:0] bcd;

    bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] exp;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    int            done_cnt = 0;
    logic [19:0]   exp_q[$];
    logic [19:0]   mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference built from division, independent of double dabble.
    function automatic logic [19:0] model(input int unsigned v);
        logic [19:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Scoreboard: every done pops one expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got bcd %0h expected no done", bcd);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("bcd_value", 32'(bcd), 32'(mon_exp));
            end
            checks++;
            for (int d = 0; d < DIGITS; d++) begin
                if (bcd[d*4 +: 4] > 4'd9) begin
                    failures++;
                    $display("FAIL digit_range: digit %0d got %0h expected <= 9", d, bcd[d*4 +: 4]);
                    break;
                end
            end
        end
    end

    // Called at posedge+#1; leaves at the accepting edge +#1.
    task automatic start_conv(input logic [15:0] v, input logic [19:0] e, input bit push);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) exp_q.push_back(e);
    endtask

    // n0 = index of the edge just passed, counting the accept edge as 1.
    task automatic wait_done(input int n0, output int lat, output int busy_n);
        int n;
        bit seen;
        n      = n0;
        seen   = 1'b0;
        busy_n = 0;
        lat    = -1;
        while (!seen && n < n0 + 64) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                if (busy) busy_n++;
                @(posedge clk);
                n++;
            end
        end
        chk("done_timeout", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[12];
    int   lat, bn, d0, t[3], e, dn;
    logic [15:0] rv;

    initial begin
        tbl[0]  = '{16'd0,     20'h00000};
        tbl[1]  = '{16'd65535, 20'h65535};
        tbl[2]  = '{16'd1234,  20'h01234};
        tbl[3]  = '{16'd9,     20'h00009};
        tbl[4]  = '{16'd10,    20'h00010};
        tbl[5]  = '{16'd99,    20'h00099};
        tbl[6]  = '{16'd100,   20'h00100};
        tbl[7]  = '{16'd10000, 20'h10000};
        tbl[8]  = '{16'd59999, 20'h59999};
        tbl[9]  = '{16'd5,     20'h00005};
        tbl[10] = '{16'd32768, 20'h32768};
        tbl[11] = '{16'd50000, 20'h50000};

        reset = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd",  32'(bcd),  32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Zero input: latency and busy length.
        start_conv(16'd0, 20'h00000, 1'b1);
        wait_done(1, lat, bn);
        chk("zero_latency", 32'(lat), 32'(LAT));
        chk("zero_busy_cycles", 32'(bn), 32'(WIDTH));

        // Table of directed values, latency checked for each.
        for (int i = 0; i < 12; i++) begin
            start_conv(tbl[i].bin, tbl[i].exp, 1'b1);
            wait_done(1, lat, bn);
            chk("tbl_latency", 32'(lat), 32'(LAT));
        end

        // start while busy is ignored.
        d0 = done_cnt;
        start_conv(16'd100, 20'h00100, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        bin   = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5, lat, bn);
        chk("busy_start_latency", 32'(lat), 32'(LAT));
        repeat (30) @(posedge clk);
        #1;
        chk("busy_start_single_done", 32'(done_cnt - d0), 32'd1);
        chk("bcd_hold", 32'(bcd), 32'h00100);

        // start held high: back-to-back conversions every LAT cycles.
        start = 1'b1;
        bin   = 16'd4321;
        exp_q.push_back(20'h04321);
        e  = 0;
        dn = 0;
        while (dn < 3 && e < 100) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (done) begin
                t[dn] = e;
                dn++;
                if (dn < 3) exp_q.push_back(20'h04321);
                else start = 1'b0;
            end
        end
        chk("b2b_count", 32'(dn), 32'd3);
        chk("b2b_first", 32'(t[0]), 32'(LAT));
        chk("b2b_period1", 32'(t[1] - t[0]), 32'(LAT));
        chk("b2b_period2", 32'(t[2] - t[1]), 32'(LAT));
        @(posedge clk);
        #1;

        // Reset mid-conversion aborts with no done afterwards.
        start_conv(16'd500, 20'h00500, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_bcd",  32'(bcd),  32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_bcd", 32'(bcd), 32'd0);

        // First start after reset behaves normally.
        start_conv(16'd1234, 20'h01234, 1'b1);
        wait_done(1, lat, bn);
        chk("post_reset_latency", 32'(lat), 32'(LAT));

        // Random sweep against the decimal model.
        for (int i = 0; i < NRAND; i++) begin
            rv = 16'($urandom);
            start_conv(rv, model(32'(rv)), 1'b1);
            wait_done(1, lat, bn);
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bin_to_bcd
